conv_mul_arbiter: RTL and testbench
===================================

CONV_MUL_ARBITER -- requirements
Module: conv_mul_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, number of requesters sharing one multiplier (2..8).
REQ-002 SHALL have parameter DIN_WIDTH, default 31, unsigned operand width.
REQ-003 SHALL have parameter DOUT_WIDTH, default 62, product width, equal to 2*DIN_WIDTH.
REQ-004 SHALL have parameter ID_WIDTH, default 2, requester tag width, equal to clog2(NUM_REQ).
REQ-005 SHALL have clk  input  1  single clock, all logic on rising edge.
REQ-006 SHALL have reset  input  1  synchronous, active-low reset.
REQ-007 SHALL have req_valid  input  NUM_REQ  per-requester operand valid.
REQ-008 SHALL have req_ready  output  NUM_REQ  per-requester accept, one-hot or zero.
REQ-009 SHALL have req_a  input  NUM_REQ*DIN_WIDTH  flat operand A, requester i at slice i.
REQ-010 SHALL have req_b  input  NUM_REQ*DIN_WIDTH  flat operand B, same packing.
REQ-011 SHALL have rsp_valid  output  1  product valid.
REQ-012 SHALL have rsp_ready  input  1  consumer accept.
REQ-013 SHALL have rsp_id  output  ID_WIDTH  index of requester owning rsp_data.
REQ-014 SHALL have rsp_data  output  DOUT_WIDTH  unsigned product.
REQ-015 SHALL have grant_cnt  output  NUM_REQ*16  per-requester grant counters (see Configuration).

Function
REQ-016 SHALL form a 2-stage pipeline: stage 1 holds registered operands, id and valid; stage 2 is the multiplier product register plus aligned id and valid.
REQ-017 SHALL drive a shared advance enable: adv = !(s2_valid && !rsp_ready); adv gates stage 1 registers, the multiplier ce and stage 2 valid/id.
REQ-018 SHALL arbitrate round-robin: search starts at pointer ptr, first i (mod NUM_REQ) with req_valid[i] wins.
REQ-019 SHALL assert req_ready[i] only when i wins and adv=1; a handshake is req_valid[i] && req_ready[i].
REQ-020 SHALL update ptr to (winner+1) mod NUM_REQ on each handshake; ptr holds otherwise.
REQ-021 SHALL compute rsp_data as the zero-extended unsigned product of the accepted A and B, full DOUT_WIDTH, no truncation.
REQ-022 SHALL present a handshake accepted at edge N as rsp_valid at edge N+2 when adv stays 1 (latency 2).
REQ-023 SHALL hold rsp_valid, rsp_id and rsp_data stable while rsp_valid=1 and rsp_ready=0, with no new grants.
REQ-024 SHALL sustain one handshake per cycle when rsp_ready is held 1.
REQ-025 SHALL ignore req_a/req_b of non-granted requesters; a requester that drops req_valid before grant is not served.
REQ-026 SHALL leave stage 1 valid at 0 after an advance with no requester valid (bubble), and propagate bubbles.

Reset
REQ-027 SHALL, when reset=0 at a rising edge, clear stage 1 and stage 2 valid, set ptr to 0 and drive req_ready=0 and rsp_valid=0 in the following cycle.
REQ-028 SHALL discard in-flight operations on reset mid-operation; no response is produced for them.
REQ-029 SHALL leave data registers (operands, product) without reset; rsp_id and rsp_data are don't-care while rsp_valid=0.

Configuration
REQ-030 SHALL, with CONV_MUL_ARB_STATS_EN defined, keep a 16-bit saturating counter per requester, incremented on each handshake, held at 0xFFFF once reached, and cleared by reset.
REQ-031 SHALL, without CONV_MUL_ARB_STATS_EN, keep the grant_cnt port present, tied to 0, with no counter logic.

Structure
REQ-032 SHALL take default widths, NUM_REQ and the counter width from a shared package conv_mul_arb_pkg.
REQ-033 SHALL implement the round-robin pointer and winner search as sub-module conv_mul_rr_arb with inputs req, adv and outputs one-hot grant and winner index.
REQ-034 SHALL instantiate the codebase's existing unsigned DIN_WIDTH x DIN_WIDTH multiplier core (one registered stage, ce-gated) for stage 2, with ce=adv.

Verification
REQ-035 SHALL check: all 4 valid, rsp_ready=1 -> grants 0,1,2,3,0 on consecutive cycles; rsp_id follows 2 cycles later.
REQ-036 SHALL check: req 2 only, A=0x7FFFFFFF, B=0x7FFFFFFF -> rsp_data=0x3FFFFFFF00000001, rsp_id=2 at handshake+2.
REQ-037 SHALL check: rsp_ready=0 for 5 cycles with rsp_valid=1 -> outputs stable, req_ready=0; on release, one response per cycle resumes with no loss or duplication.
REQ-038 SHALL check: reset=0 with both stages valid -> rsp_valid=0 next cycle, ptr=0, and no stale response appears after reset release.
REQ-039 SHALL check: with STATS enabled, 70000 grants to requester 1 -> grant_cnt slice 1 = 0xFFFF; without STATS -> grant_cnt=0.
REQ-040 SHALL check: random valid/ready traffic against a scoreboard model -> every accepted operand pair yields exactly one correct product in per-requester order.

Source files
------------

// File: rtl/conv_mul_arb_pkg.sv
// Shared defaults for the conv_mul_arbiter slice: requester count, operand/product widths
// and the grant statistics counter width.
package conv_mul_arb_pkg;
    localparam int NUM_REQ_DEF    = 4;
    localparam int DIN_WIDTH_DEF  = 31;
    localparam int DOUT_WIDTH_DEF = 2 * DIN_WIDTH_DEF;
    localparam int ID_WIDTH_DEF   = $clog2(NUM_REQ_DEF);
    localparam int CNT_WIDTH      = 16;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;
endpackage

// File: rtl/conv_mul_core.sv
// Unsigned DIN_WIDTH x DIN_WIDTH multiplier with a single ce-gated output register.
module conv_mul_core #(
    parameter int DIN_WIDTH  = 31,
    parameter int DOUT_WIDTH = 62
) (
    input  logic                  clk,
    input  logic                  ce,
    input  logic [DIN_WIDTH-1:0]  a,
    input  logic [DIN_WIDTH-1:0]  b,
    output logic [DOUT_WIDTH-1:0] p
);
    always_ff @(posedge clk) begin
        if (ce) p <= DOUT_WIDTH'(a) * DOUT_WIDTH'(b);
    end
endmodule

// File: rtl/conv_mul_rr_arb.sv
// Round-robin arbiter: the search starts at ptr, and ptr moves past the winner on every grant.
// The grant is one-hot and is only raised while adv is high.
module conv_mul_rr_arb
    import conv_mul_arb_pkg::*;
#(
    parameter int NUM_REQ  = NUM_REQ_DEF,
    parameter int ID_WIDTH = ID_WIDTH_DEF
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_REQ-1:0]  req,
    input  logic                adv,
    output logic [NUM_REQ-1:0]  grant,
    output logic [ID_WIDTH-1:0] winner,
    output logic                found
);
    logic [ID_WIDTH-1:0] ptr;

    always_comb begin
        found  = 1'b0;
        winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (!found && req[(int'(ptr) + k) % NUM_REQ]) begin
                found  = 1'b1;
                winner = ID_WIDTH'((int'(ptr) + k) % NUM_REQ);
            end
        end
        grant = '0;
        if (found && adv) grant[winner] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            ptr <= '0;
        end else if (|grant) begin
            ptr <= (winner == ID_WIDTH'(NUM_REQ - 1)) ? '0 : winner + 1'b1;
        end
    end
endmodule

// File: rtl/conv_mul_arbiter.sv
// NUM_REQ requesters share one two-stage multiplier through round-robin arbitration.
// Define CONV_MUL_ARB_STATS_EN to enable the per-requester saturating grant counters.
module conv_mul_arbiter
    import conv_mul_arb_pkg::*;
#(
    parameter int NUM_REQ    = NUM_REQ_DEF,
    parameter int DIN_WIDTH  = DIN_WIDTH_DEF,
    parameter int DOUT_WIDTH = DOUT_WIDTH_DEF,
    parameter int ID_WIDTH   = ID_WIDTH_DEF
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NUM_REQ-1:0]             req_valid,
    output logic [NUM_REQ-1:0]             req_ready,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_a,
    input  logic [NUM_REQ*DIN_WIDTH-1:0]   req_b,
    output logic                           rsp_valid,
    input  logic                           rsp_ready,
    output logic [ID_WIDTH-1:0]            rsp_id,
    output logic [DOUT_WIDTH-1:0]          rsp_data,
    output logic [NUM_REQ*CNT_WIDTH-1:0]   grant_cnt
);
    // Handshakes: a transfer happens on a rising edge where valid && ready. Requesters may
    // drop valid before being granted. rsp_valid/rsp_id/rsp_data hold steady until rsp_ready.
    logic                  adv;
    logic                  arb_adv;
    logic                  found;
    logic [NUM_REQ-1:0]    grant;
    logic [ID_WIDTH-1:0]   winner;
    logic [DIN_WIDTH-1:0]  sel_a, sel_b;
    logic                  s1_valid, s2_valid;
    logic [ID_WIDTH-1:0]   s1_id, s2_id;
    logic [DIN_WIDTH-1:0]  s1_a, s1_b;
    logic [DOUT_WIDTH-1:0] product;

    assign adv     = !(s2_valid && !rsp_ready);
    // No grants while reset is held low, so nothing is accepted and then discarded.
    assign arb_adv = adv && reset;

    conv_mul_rr_arb #(.NUM_REQ(NUM_REQ), .ID_WIDTH(ID_WIDTH)) u_arb (
        .clk    (clk),
        .reset  (reset),
        .req    (req_valid),
        .adv    (arb_adv),
        .grant  (grant),
        .winner (winner),
        .found  (found)
    );

    assign req_ready = grant;

    always_comb begin
        sel_a = '0;
        sel_b = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (ID_WIDTH'(i) == winner) begin
                sel_a = req_a[i*DIN_WIDTH +: DIN_WIDTH];
                sel_b = req_b[i*DIN_WIDTH +: DIN_WIDTH];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            s1_valid <= 1'b0;
            s2_valid <= 1'b0;
        end else if (adv) begin
            s1_valid <= |grant;
            s2_valid <= s1_valid;
        end
    end

    // The operand and id registers are not reset; they only matter while the matching valid is set.
    always_ff @(posedge clk) begin
        if (adv) begin
            s1_a  <= sel_a;
            s1_b  <= sel_b;
            s1_id <= winner;
            s2_id <= s1_id;
        end
    end

    conv_mul_core #(.DIN_WIDTH(DIN_WIDTH), .DOUT_WIDTH(DOUT_WIDTH)) u_mul (
        .clk (clk),
        .ce  (adv),
        .a   (s1_a),
        .b   (s1_b),
        .p   (product)
    );

    assign rsp_valid = s2_valid;
    assign rsp_id    = s2_id;
    assign rsp_data  = product;

`ifdef CONV_MUL_ARB_STATS_EN
    for (genvar i = 0; i < NUM_REQ; i++) begin : g_cnt
        logic [CNT_WIDTH-1:0] cnt;
        always_ff @(posedge clk) begin
            if (!reset) begin
                cnt <= '0;
            end else if (grant[i] && cnt != CNT_MAX) begin
                cnt <= cnt + 1'b1;
            end
        end
        assign grant_cnt[i*CNT_WIDTH +: CNT_WIDTH] = cnt;
    end
`else
    assign grant_cnt = '0;
`endif
endmodule

// File: tb/tb_conv_mul_arbiter.sv
// Bench for conv_mul_arbiter: directed cases plus random traffic, with a round-robin reference
// model feeding an expected-response queue that a separate monitor drains.
module tb_conv_mul_arbiter;
    localparam int N  = 4;
    localparam int DW = 31;
    localparam int OW = 62;
    localparam int IW = 2;
    localparam int CW = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [N-1:0]    req_valid;
    logic [N-1:0]    req_ready;
    logic [N*DW-1:0] req_a, req_b;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [IW-1:0]   rsp_id;
    logic [OW-1:0]   rsp_data;
    logic [N*CW-1:0] grant_cnt;

    int total = 0;
    int bad   = 0;
    int n_rsp = 0;
    logic [IW+OW-1:0] exp_q[$];

    // reference model state
    int           m_ptr = 0;
    bit           m_v0  = 1'b0;
    bit           m_v1  = 1'b0;
    int           m_cnt[N];
    int           m_w;
    bit           m_found;
    logic [N-1:0] m_eg;

    always #5 clk = ~clk;

    conv_mul_arbiter dut (
        .clk       (clk),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_a     (req_a),
        .req_b     (req_b),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_id    (rsp_id),
        .rsp_data  (rsp_data),
        .grant_cnt (grant_cnt)
    );

    function automatic logic [OW-1:0] ref_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        longint unsigned p;
        p = longint'(a) * longint'(b);
        return OW'(p);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", name, act, req, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic rand_data();
        for (int i = 0; i < N; i++) begin
            req_a[i*DW +: DW] = DW'($urandom);
            req_b[i*DW +: DW] = DW'($urandom);
        end
    endtask

    // Reference model: decides the winner from the request mask and pointer, predicts the
    // request-side handshake and output occupancy, and queues the expected response.
    always @(negedge clk) begin
        #1;
        m_found = 1'b0;
        m_w     = 0;
        for (int k = 0; k < N; k++) begin
            if (!m_found && req_valid[(m_ptr + k) % N]) begin
                m_found = 1'b1;
                m_w     = (m_ptr + k) % N;
            end
        end
        m_eg = '0;
        if (reset && !(m_v1 && !rsp_ready) && m_found) m_eg[m_w] = 1'b1;
        check("req_ready", 64'(req_ready), 64'(m_eg));
        check("rsp_valid", 64'(rsp_valid), 64'(m_v1));
`ifdef CONV_MUL_ARB_STATS_EN
        for (int i = 0; i < N; i++)
            check("grant_cnt", 64'(grant_cnt[i*CW +: CW]), 64'(m_cnt[i]));
`else
        check("grant_cnt_zero", 64'(grant_cnt), 64'd0);
`endif
        if (!reset) begin
            m_v0  = 1'b0;
            m_v1  = 1'b0;
            m_ptr = 0;
            exp_q.delete();
            foreach (m_cnt[i]) m_cnt[i] = 0;
        end else if (!(m_v1 && !rsp_ready)) begin
            m_v1 = m_v0;
            m_v0 = (m_eg != '0);
            if (m_eg != '0) begin
                exp_q.push_back({IW'(m_w), ref_mul(req_a[m_w*DW +: DW], req_b[m_w*DW +: DW])});
                m_ptr = (m_w + 1) % N;
                if (m_cnt[m_w] < 65535) m_cnt[m_w]++;
            end
        end
    end

    // Monitor: every presented response must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rsp_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL rsp_unexpected: got id %0d data %0h want no response", rsp_id, rsp_data);
            end else begin
                check("rsp", {rsp_id, rsp_data}, exp_q[0]);
                if (rsp_ready) begin
                    void'(exp_q.pop_front());
                    n_rsp++;
                end
            end
        end
    end

    initial begin
        foreach (m_cnt[i]) m_cnt[i] = 0;
        reset     = 1'b0;
        req_valid = '0;
        req_a     = '0;
        req_b     = '0;
        rsp_ready = 1'b0;
        repeat (2) step();
        reset = 1'b1;

        // all requesters valid: grants rotate 0,1,2,3,0
        rsp_ready = 1'b1;
        req_valid = '1;
        for (int c = 0; c < 5; c++) begin
            rand_data();
            step();
        end
        req_valid = '0;
        repeat (3) step();

        // largest operands on requester 2
        req_a[2*DW +: DW] = 31'h7FFFFFFF;
        req_b[2*DW +: DW] = 31'h7FFFFFFF;
        req_valid = 4'b0100;
        step();
        req_valid = '0;
        step();
        #3;
        check("max_product_data", 64'(rsp_data), 64'h3FFFFFFF00000001);
        check("max_product_id", 64'(rsp_id), 64'd2);
        check("max_product_valid", 64'(rsp_valid), 64'd1);
        step();

        // back-pressure for 5 cycles with both stages full, then release
        req_valid = '1;
        rand_data();
        repeat (2) step();
        rsp_ready = 1'b0;
        repeat (5) begin
            rand_data();
            step();
        end
        rsp_ready = 1'b1;
        repeat (6) begin
            rand_data();
            step();
        end

        // reset with both stages valid
        rsp_ready = 1'b0;
        reset     = 1'b0;
        repeat (2) step();
        reset     = 1'b1;
        rsp_ready = 1'b1;
        repeat (3) begin
            rand_data();
            step();
        end
        req_valid = '0;
        repeat (3) step();

        // random traffic
        for (int c = 0; c < 3000; c++) begin
            req_valid = N'($urandom_range(0, (1 << N) - 1));
            rsp_ready = ($urandom_range(0, 9) < 7);
            rand_data();
            step();
        end

`ifdef CONV_MUL_ARB_STATS_EN
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        repeat (70000) begin
            rand_data();
            step();
        end
        #3;
        check("grant_cnt_sat", 64'(grant_cnt[1*CW +: CW]), 64'hFFFF);
`endif

        // drain
        req_valid = '0;
        rsp_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) step();
        step();
        check("drain_empty", 64'(exp_q.size()), 64'd0);
        check("responses_seen", 64'(n_rsp > 500), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
